// File: rtl/hazard_issue_ctrl_if.sv
// ID-stage issue/stall handshake between the pipeline and hazard_issue_ctrl.
// The pipeline side (master) presents the instruction; the controller (slave) answers.
interface hazard_issue_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             run;
  logic             id_valid;
  logic [15:0]      id_instr;
  logic             issue;
  logic             hold_if;
  logic             bubble;
  logic [7:0]       busy_mask;
  logic             idle;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output run, id_valid, id_instr,
    input  issue, hold_if, bubble, busy_mask, idle, issue_cnt, stall_cnt
  );

  modport slave (
    input  run, id_valid, id_instr,
    output issue, hold_if, bubble, busy_mask, idle, issue_cnt, stall_cnt
  );
endinterface

// File: rtl/hazard_issue_ctrl.sv
// ID-stage scoreboard: tracks in-flight register writes, stalls RAW/WAW hazards and
// counts issues and stall cycles. No forwarding exists, so stalls cover full latency.
module hazard_issue_ctrl #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ALU_LAT  = 2,
  parameter int unsigned LOAD_LAT = 3,
  parameter int unsigned CNT_W    = 16
) (
  input logic                clk,
  input logic                reset,
  hazard_issue_ctrl_if.slave bus
);

  localparam logic [1:0] AluLat  = 2'(ALU_LAT);
  localparam logic [1:0] LoadLat = 2'(LOAD_LAT);

  logic [1:0]          cnt_q [NUM_REGS];
  logic [1:0]          cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic [1:0] op;
  logic [2:0] rs1, rs2, rd;
  logic       reads_rs2, writes_rd, is_load;
  logic       hazard, issue, stall;
  logic       unused_instr_bits;

  assign op                = bus.id_instr[15:14];
  assign rs1               = bus.id_instr[13:11];
  assign rs2               = bus.id_instr[10:8];
  assign rd                = bus.id_instr[7:5];
  assign unused_instr_bits = ^bus.id_instr[4:0];

  assign reads_rs2 = (op != 2'b10);
  assign writes_rd = (op != 2'b11);
  assign is_load   = (op == 2'b10);

  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      busy[r] = (cnt_q[r] != 2'd0);
    end
  end

  // Only state from earlier issues counts; rd == rs of the same instruction is fine.
  assign hazard = busy[rs1] | (reads_rs2 & busy[rs2]) | (writes_rd & busy[rd]);
  assign issue  = bus.id_valid & bus.run & ~hazard;
  assign stall  = bus.id_valid & bus.run & hazard;

  // WAW blocking means a reload never lands on a nonzero counter.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (issue && writes_rd && (rd == 3'(r))) begin
        cnt_d[r] = is_load ? LoadLat : AluLat;
      end else if (busy[r]) begin
        cnt_d[r] = cnt_q[r] - 2'd1;
      end
    end
  end

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (issue && (issue_cnt_q != '1)) begin
      issue_cnt_d = issue_cnt_q + CNT_W'(1);
    end
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= 2'd0;
      end
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.issue     = issue;
  assign bus.hold_if   = bus.id_valid & ~issue;
  assign bus.bubble    = ~issue;
  assign bus.busy_mask = busy;
  assign bus.idle      = (busy == '0);
  assign bus.issue_cnt = issue_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_issue_ctrl.sv
// Bench for hazard_issue_ctrl: directed pipeline sequences plus random traffic, checked
// against a model that records the cycle at which each register becomes readable.
module tb_hazard_issue_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic sreset;

  always #5 clk = ~clk;

  hazard_issue_ctrl_if #(.CNT_W(16)) bus ();
  hazard_issue_ctrl_if #(.CNT_W(4))  sbus ();

  hazard_issue_ctrl #(.CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Narrow counters so saturation is reachable in a short run.
  hazard_issue_ctrl #(.CNT_W(4)) dut_sat (
    .clk   (clk),
    .reset (sreset),
    .bus   (sbus)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: register r is readable from cycle ready_at[r] onward.
  int cyc = 0;
  int ready_at [8];
  int exp_issues = 0;
  int exp_stalls = 0;
  bit got_issue;

  function automatic logic [15:0] mk(int op, int rs1, int rs2, int rd);
    logic [1:0] o;
    logic [2:0] a, b, d;
    o = 2'(op); a = 3'(rs1); b = 3'(rs2); d = 3'(rd);
    return {o, a, b, d, 5'b00000};
  endfunction

  function automatic bit busy_now(int r);
    return cyc < ready_at[r];
  endfunction

  function automatic logic [7:0] exp_mask();
    logic [7:0] m;
    for (int r = 0; r < 8; r++) m[r] = busy_now(r);
    return m;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int r = 0; r < 8; r++) ready_at[r] = 0;
    exp_issues = 0;
    exp_stalls = 0;
  endtask

  // One pipeline cycle: drive, check combinational and registered outputs, advance model.
  task automatic step(bit r, bit v, logic [15:0] ins);
    int  op, s1, s2, d;
    bit  haz, ei;
    bus.run = r; bus.id_valid = v; bus.id_instr = ins;
    #1;
    op = int'(ins[15:14]); s1 = int'(ins[13:11]); s2 = int'(ins[10:8]); d = int'(ins[7:5]);
    haz = busy_now(s1) || (op != 2 && busy_now(s2)) || (op != 3 && busy_now(d));
    ei  = v && r && !haz;
    chk("issue",     32'(bus.issue),     32'(ei));
    chk("hold_if",   32'(bus.hold_if),   32'(v && !ei));
    chk("bubble",    32'(bus.bubble),    32'(!ei));
    chk("busy_mask", 32'(bus.busy_mask), 32'(exp_mask()));
    chk("idle",      32'(bus.idle),      32'(exp_mask() == 8'h00));
    chk("issue_cnt", 32'(bus.issue_cnt), 32'(exp_issues));
    chk("stall_cnt", 32'(bus.stall_cnt), 32'(exp_stalls));
    got_issue = bus.issue;
    if (ei) begin
      if (exp_issues < 65535) exp_issues++;
      if (op != 3) ready_at[d] = cyc + ((op == 2) ? 3 : 2) + 1;
    end
    if (v && r && haz && exp_stalls < 65535) exp_stalls++;
    @(posedge clk);
    cyc++;
    #2;
  endtask

  initial begin
    model_reset();
    reset = 1'b0;
    sreset = 1'b0;
    bus.run = 1'b1; bus.id_valid = 1'b0; bus.id_instr = '0;
    sbus.run = 1'b1; sbus.id_valid = 1'b1; sbus.id_instr = mk(0, 1, 1, 1);
    #1;
    chk("rst_busy_mask", 32'(bus.busy_mask), 32'h0);
    chk("rst_idle",      32'(bus.idle),      32'h1);
    chk("rst_issue_cnt", 32'(bus.issue_cnt), 32'h0);
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
    chk("rst_bubble",    32'(bus.bubble),    32'h1);
    #1;
    sreset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b1;

    // ADD R3 then dependent SUB R4=R3-R1: two stall cycles.
    step(1, 1, mk(0, 1, 2, 3));
    chk("add_mask", 32'(bus.busy_mask), 32'h08);
    step(1, 1, mk(1, 3, 1, 4));
    chk("sub_c1", 32'(got_issue), 32'h0);
    step(1, 1, mk(1, 3, 1, 4));
    chk("sub_c2", 32'(got_issue), 32'h0);
    step(1, 1, mk(1, 3, 1, 4));
    chk("sub_c3", 32'(got_issue), 32'h1);
    chk("sub_stalls", 32'(bus.stall_cnt), 32'd2);
    chk("sub_issues", 32'(bus.issue_cnt), 32'd2);

    // Independent LOAD R6, then ADD R7=R6+R1 waits three cycles.
    step(1, 1, mk(2, 5, 0, 6));
    chk("load_issue", 32'(got_issue), 32'h1);
    chk("load_bit6",  32'(bus.busy_mask[6]), 32'h1);
    chk("load_stall", 32'(bus.stall_cnt), 32'd2);
    for (int i = 0; i < 4; i++) step(1, 1, mk(0, 6, 1, 7));
    chk("add7_issue", 32'(got_issue), 32'h1);

    // WAW on R3, then STORE blocked by rs2 = R3.
    for (int i = 0; i < 3; i++) step(1, 0, '0);
    step(1, 1, mk(0, 1, 2, 3));
    for (int i = 0; i < 3; i++) step(1, 1, mk(2, 5, 0, 3));
    chk("waw_issue", 32'(got_issue), 32'h1);
    for (int i = 0; i < 5; i++) step(1, 1, mk(3, 2, 3, 0));
    chk("store_issue", 32'(got_issue), 32'h1);

    // run=0 with a dependent instruction: scoreboard drains, no stall counting.
    for (int i = 0; i < 4; i++) step(1, 0, '0);
    step(1, 1, mk(0, 1, 2, 3));
    for (int i = 0; i < 5; i++) begin
      step(0, 1, mk(1, 3, 1, 4));
      if (i == 1) chk("run0_idle", 32'(bus.idle), 32'h1);
    end
    step(1, 1, mk(1, 3, 1, 4));
    chk("run1_issue", 32'(got_issue), 32'h1);

    // Asynchronous reset in the middle of a stall.
    for (int i = 0; i < 4; i++) step(1, 0, '0);
    step(1, 1, mk(0, 1, 2, 3));
    step(1, 1, mk(1, 3, 1, 4));
    chk("pre_rst_mask", 32'(bus.busy_mask), 32'h08);
    reset = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_mask",  32'(bus.busy_mask), 32'h0);
    chk("mid_rst_issue_cnt", 32'(bus.issue_cnt), 32'h0);
    chk("mid_rst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
    chk("mid_rst_issue", 32'(bus.issue), 32'h1);
    #1;
    reset = 1'b1;
    step(1, 1, mk(1, 3, 1, 4));
    chk("post_rst_issue", 32'(got_issue), 32'h1);

    // Random traffic over a small register window to provoke hazards.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 4) != 0),
           mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3))));
    end

    // Narrow-counter instance has been stalling throughout: both counters pinned.
    for (int i = 0; i < 3; i++) begin
      chk("sat_stall_cnt", 32'(sbus.stall_cnt), 32'hF);
      chk("sat_issue_cnt", 32'(sbus.issue_cnt), 32'hF);
      @(posedge clk);
      #2;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
